pc_control_unit: RTL and testbench
==================================

# pc_control_unit

Program-counter control for the instruction-fetch stage of the single-issue MIPS pipeline. The block holds the 32-bit PC register and computes the next PC combinationally. The next PC is the sequential, branch, jump or jump-register target, selected from the control and datapath inputs. The PC advances only when the instruction fetch is not stalled by the instruction cache.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_b  in  1  reset, asynchronous and active-low.
- jump  in  2  jump type: 2'b00 none, 2'b01 J, 2'b10 JAL, 2'b11 reserved (treated as none).
- branch  in  3  branch type: 3'b000 none, 3'b001 BEQ, 3'b010 BNE, all other codes reserved (treated as none).
- jr  in  1  jump-register (JR/JALR); target is rs_data.
- zero  in  1  ALU zero flag from the compare of the current branch.
- address  in  26  instruction jump field, inst[25:0].
- sign_extend_immediate  in  32  sign-extended 16-bit branch offset, in words.
- rs_data  in  32  register rs value, the JR target.
- cache_en  in  1  instruction cache enabled.
- hit  in  1  instruction cache hit for the current PC.
- pc  out  32  current PC, registered, byte address.
- next_pc  out  32  combinational next-PC value.
- pc_plus4  out  32  pc + 4, for JAL link writeback.

## Operation
- pc_plus4 = pc + 4, computed modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Branch target = pc_plus4 + (sign_extend_immediate << 2), 32-bit, modulo 2^32; the shifted-out high bits are discarded.
- Jump target = {pc_plus4[31:28], address, 2'b00}.
- Branch taken: BEQ when zero=1; BNE when zero=0; never for reserved codes.
- next_pc is selected in priority order:
  - jr=1 → rs_data, used unaligned as given with no masking.
  - otherwise jump ∈ {J, JAL} → jump target.
  - otherwise branch taken → branch target.
  - otherwise → pc_plus4.
- Simultaneous requests resolve by this priority; no error is flagged.
- advance = !cache_en || hit.
- PC register:
  - on rst_b=0 → pc = RESET_PC.
  - on a rising edge with advance=1 → pc = next_pc.
  - otherwise pc holds.
- JAL link-register write is outside this block; the block only exposes pc_plus4.

## Timing
- next_pc and pc_plus4 are purely combinational from pc and the inputs, with zero latency.
- The PC update has one-cycle latency: the next_pc present before a rising edge appears on pc after that edge.
- Reset asserts asynchronously: pc goes to RESET_PC immediately, independent of clk.
- Reset release: the first rising edge with rst_b=1 and advance=1 loads next_pc, which is RESET_PC+4 with no control active.
- Reset mid-stall or mid-branch: reset wins, and the pending redirect is lost.
- Stall (cache_en=1, hit=0): pc holds for as many cycles as the miss lasts, while next_pc keeps tracking the inputs. The redirect is applied on the edge where hit=1.
- No internal state other than pc; the block has no handshakes beyond advance.

## Structure
- Shared package pc_control_pkg holds:
  - the JUMP_NONE/JUMP_J/JUMP_JAL encodings.
  - the BR_NONE/BR_BEQ/BR_BNE encodings.
  - the constant PC_STEP = 4.
- One combinational sub-module, pc_next_logic, computes pc_plus4, the branch and jump targets, and next_pc.
- The top level adds only the advance logic and the PC register.

## Test plan
- Reset and sequential fetch: assert rst_b=0 → pc=0 without a clock edge. Release with no control and cache_en=0, run 3 edges → pc = 4, 8, 12.
- Branches at pc=0x100 with imm=0xFFFF_FFFE:
  - BEQ, zero=1 → next_pc=0xFC.
  - BEQ, zero=0 → next_pc=0x104.
  - BNE, zero=0 → next_pc=0xFC.
- Jump and JR:
  - pc=0x1000_0010, jump=J, address=0x0000040 → next_pc=0x1000_0100.
  - jr=1 with jump=J, branch=BEQ, zero=1, rs_data=0x0040_0020 → next_pc=0x0040_0020 (jr has priority).
- Cache stall: cache_en=1, hit=0 for 3 edges at pc=0x20 → pc stays 0x20. hit=1 → pc=0x24 on the next edge. cache_en=0, hit=0 → pc advances.
- Wrap-around and reserved codes:
  - pc=0xFFFF_FFFC, no control → pc=0 after one edge.
  - jump=2'b11 or branch=3'b111 with zero=1 → next_pc=pc+4.
- Asynchronous reset mid-stall: pc=0x80, cache_en=1, hit=0, pulse rst_b low between edges → pc=0 immediately. After release with cache_en=0 → pc=4.

Source files
------------

// File: rtl/pc_control_pkg.sv
// Shared encodings and constants for the instruction-fetch PC control path.
package pc_control_pkg;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JAL  = 2'b10;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_control_unit_pc_next_logic.sv
// Combinational next-PC selection: sequential, branch, jump or jump-register target.
module pc_next_logic
  import pc_control_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  jump,
  input  logic [2:0]  branch,
  input  logic        jr,
  input  logic        zero,
  input  logic [25:0] address,
  input  logic [31:0] sign_extend_immediate,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        jump_taken;
  logic        branch_taken;

  // All arithmetic is 32-bit and wraps; bits shifted out of the offset are dropped.
  assign pc_plus4      = pc + PC_STEP;
  assign branch_target = pc_plus4 + (sign_extend_immediate << 2);
  assign jump_target   = {pc_plus4[31:28], address, 2'b00};

  assign jump_taken   = (jump == JUMP_J) || (jump == JUMP_JAL);
  assign branch_taken = ((branch == BR_BEQ) &&  zero) ||
                        ((branch == BR_BNE) && !zero);

  always_comb begin
    next_pc = pc_plus4;
    if (jr)                next_pc = rs_data;
    else if (jump_taken)   next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
  end

endmodule

// File: rtl/pc_control_unit.sv
// Fetch-stage PC register; advances to next_pc unless the instruction cache misses.
module pc_control_unit
  import pc_control_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [1:0]  jump,
  input  logic [2:0]  branch,
  input  logic        jr,
  input  logic        zero,
  input  logic [25:0] address,
  input  logic [31:0] sign_extend_immediate,
  input  logic [31:0] rs_data,
  input  logic        cache_en,
  input  logic        hit,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic advance;

  pc_next_logic u_pc_next_logic (
    .pc                    (pc),
    .jump                  (jump),
    .branch                (branch),
    .jr                    (jr),
    .zero                  (zero),
    .address               (address),
    .sign_extend_immediate (sign_extend_immediate),
    .rs_data               (rs_data),
    .next_pc               (next_pc),
    .pc_plus4              (pc_plus4)
  );

  // Only flow control: a rising edge with advance=1 consumes next_pc; a
  // cache miss (cache_en=1, hit=0) holds pc and the redirect waits for the hit.
  assign advance = !cache_en || hit;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       pc <= RESET_PC;
    else if (advance) pc <= next_pc;
  end

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit with an expected-value queue.
module tb_pc_control_unit;

  logic        clk;
  logic        rst_b;
  logic [1:0]  jump;
  logic [2:0]  branch;
  logic        jr;
  logic        zero;
  logic [25:0] address;
  logic [31:0] sign_extend_immediate;
  logic [31:0] rs_data;
  logic        cache_en;
  logic        hit;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  pc_control_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk                   (clk),
    .rst_b                 (rst_b),
    .jump                  (jump),
    .branch                (branch),
    .jr                    (jr),
    .zero                  (zero),
    .address               (address),
    .sign_extend_immediate (sign_extend_immediate),
    .rs_data               (rs_data),
    .cache_en              (cache_en),
    .hit                   (hit),
    .pc                    (pc),
    .next_pc               (next_pc),
    .pc_plus4              (pc_plus4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    jump = 2'b00; branch = 3'b000; jr = 1'b0; zero = 1'b0;
    address = '0; sign_extend_immediate = '0; rs_data = '0;
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic load_pc(input logic [31:0] v);
    cache_en = 1'b0; hit = 1'b0;
    jr = 1'b1; rs_data = v;
    push_exp(v);
    step();
    check("load_pc", pc);
    clear_ctrl();
  endtask

  initial begin
    rst_b = 1'b1; cache_en = 1'b0; hit = 1'b0;
    clear_ctrl();

    // asynchronous reset without a clock edge
    #1 rst_b = 1'b0;
    #1;
    push_exp(32'h0); check("reset_async", pc);
    step(); step();
    push_exp(32'h0); check("reset_hold", pc);
    rst_b = 1'b1;
    push_exp(32'h4); check("reset_next_pc", next_pc);

    // sequential fetch
    for (int i = 1; i <= 3; i++) begin
      push_exp(32'(4 * i));
      step();
      check("seq_fetch", pc);
    end

    // branches at 0x100, offset -2 words
    load_pc(32'h0000_0100);
    sign_extend_immediate = 32'hFFFF_FFFE;
    push_exp(32'h0000_0104); check("pc_plus4", pc_plus4);
    branch = 3'b001; zero = 1'b1; #1;
    push_exp(32'h0000_00FC); check("beq_taken", next_pc);
    zero = 1'b0; #1;
    push_exp(32'h0000_0104); check("beq_not_taken", next_pc);
    branch = 3'b010; zero = 1'b0; #1;
    push_exp(32'h0000_00FC); check("bne_taken", next_pc);
    zero = 1'b1; #1;
    push_exp(32'h0000_0104); check("bne_not_taken", next_pc);
    zero = 1'b0; #1;
    push_exp(32'h0000_00FC);
    step();
    check("bne_pc_update", pc);
    clear_ctrl();

    // jump and jump-register priority
    load_pc(32'h1000_0010);
    jump = 2'b01; address = 26'h0000040; #1;
    push_exp(32'h1000_0100); check("jump_j", next_pc);
    jump = 2'b10; #1;
    push_exp(32'h1000_0100); check("jump_jal", next_pc);
    push_exp(32'h1000_0014); check("jal_link", pc_plus4);
    jump = 2'b01; branch = 3'b001; zero = 1'b1;
    sign_extend_immediate = 32'h0000_0010; #1;
    push_exp(32'h1000_0100); check("jump_over_branch", next_pc);
    jr = 1'b1; rs_data = 32'h0040_0020; #1;
    push_exp(32'h0040_0020); check("jr_priority", next_pc);
    rs_data = 32'h0040_0023; #1;
    push_exp(32'h0040_0023); check("jr_unaligned", next_pc);
    clear_ctrl();

    // cache stall
    load_pc(32'h0000_0020);
    cache_en = 1'b1; hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h0000_0020);
      step();
      check("stall_hold", pc);
    end
    push_exp(32'h0000_0024); check("stall_next_pc", next_pc);
    hit = 1'b1;
    push_exp(32'h0000_0024);
    step();
    check("stall_hit", pc);
    cache_en = 1'b0; hit = 1'b0;
    push_exp(32'h0000_0028);
    step();
    check("cache_off", pc);

    // wrap-around
    load_pc(32'hFFFF_FFFC);
    push_exp(32'h0000_0000); check("wrap_plus4", pc_plus4);
    push_exp(32'h0000_0000);
    step();
    check("wrap_pc", pc);

    // reserved codes behave as none
    jump = 2'b11; #1;
    push_exp(32'h0000_0004); check("jump_reserved", next_pc);
    jump = 2'b00; branch = 3'b111; zero = 1'b1;
    sign_extend_immediate = 32'h0000_0100; #1;
    push_exp(32'h0000_0004); check("branch_reserved", next_pc);
    clear_ctrl();

    // asynchronous reset mid-stall with a pending branch
    load_pc(32'h0000_0080);
    cache_en = 1'b1; hit = 1'b0;
    branch = 3'b001; zero = 1'b1; sign_extend_immediate = 32'h0000_0008;
    push_exp(32'h0000_0080);
    step();
    check("stall_pre_reset", pc);
    #1 rst_b = 1'b0;
    #1;
    push_exp(32'h0000_0000); check("reset_mid_stall", pc);
    #1 rst_b = 1'b1;
    clear_ctrl();
    cache_en = 1'b0;
    push_exp(32'h0000_0004);
    step();
    check("after_reset", pc);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
